// File: rtl/alu_op_sequencer.sv
// Command-side sequencer for the 4-bit ALU: accept, issue operands, write back, pulse done.
// Optional feature: define ALU_FLAGS_EN to build the registered zero_flag.
module alu_op_sequencer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [9:0]       instr,
  input  logic [WIDTH-1:0] instr_imm,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_out,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic             busy,
  input  logic [1:0]       dbg_sel,
  output logic [WIDTH-1:0] dbg_data,
  output logic             zero_flag
);

  localparam int NREGS = 4;

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_ISSUE = 2'b01;
  localparam logic [1:0] S_DONE  = 2'b10;

  logic [1:0]       state_q, state_d;
  logic             ld_q, ld_d;
  logic [1:0]       rd_q, rd_d;
  logic [WIDTH-1:0] imm_q, imm_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [2:0]       alu_op_q, alu_op_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] rf_q [NREGS];
  logic [WIDTH-1:0] rf_d [NREGS];
  logic             accept_s;
  logic [WIDTH-1:0] wb_val_s;

  // Ready is gated by rst so nothing can be accepted during a reset cycle.
  assign instr_ready = (state_q == S_IDLE) && !rst;
  assign accept_s    = instr_valid && instr_ready;

  assign alu_a    = alu_a_q;
  assign alu_b    = alu_b_q;
  assign alu_op   = alu_op_q;
  assign result   = result_q;
  assign done     = done_q;
  assign busy     = busy_q;
  assign dbg_data = rf_q[dbg_sel];

  // Write-back value: immediate for LD, ALU result otherwise.
  always_comb begin
    if (ld_q) begin
      wb_val_s = imm_q;
    end else begin
      wb_val_s = alu_out;
    end
  end

  // Next-state and datapath update for the IDLE -> ISSUE -> DONE sequence.
  always_comb begin
    state_d  = state_q;
    ld_d     = ld_q;
    rd_d     = rd_q;
    imm_d    = imm_q;
    alu_a_d  = alu_a_q;
    alu_b_d  = alu_b_q;
    alu_op_d = alu_op_q;
    result_d = result_q;
    rf_d     = rf_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          ld_d     = instr[9];
          alu_op_d = instr[8:6];
          rd_d     = instr[5:4];
          imm_d    = instr_imm;
          // Operands are sampled here, so rd==rs never sees its own write-back.
          alu_a_d  = rf_q[instr[3:2]];
          alu_b_d  = rf_q[instr[1:0]];
          state_d  = S_ISSUE;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_ISSUE: begin
        rf_d[rd_q] = wb_val_s;
        result_d   = wb_val_s;
        state_d    = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    done_d = (state_d == S_DONE);
    busy_d = (state_d != S_IDLE);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      ld_q     <= 1'b0;
      rd_q     <= 2'b00;
      imm_q    <= {WIDTH{1'b0}};
      alu_a_q  <= {WIDTH{1'b0}};
      alu_b_q  <= {WIDTH{1'b0}};
      alu_op_q <= 3'b000;
      result_q <= {WIDTH{1'b0}};
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      for (int i = 0; i < NREGS; i++) begin
        rf_q[i] <= {WIDTH{1'b0}};
      end
    end else begin
      state_q  <= state_d;
      ld_q     <= ld_d;
      rd_q     <= rd_d;
      imm_q    <= imm_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
      alu_op_q <= alu_op_d;
      result_q <= result_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      for (int i = 0; i < NREGS; i++) begin
        rf_q[i] <= rf_d[i];
      end
    end
  end

`ifdef ALU_FLAGS_EN
  logic zero_q, zero_d;

  // Zero flag follows ALU write-backs only; LD leaves it untouched.
  always_comb begin
    if ((state_q == S_ISSUE) && !ld_q) begin
      zero_d = (alu_out == {WIDTH{1'b0}});
    end else begin
      zero_d = zero_q;
    end
  end

  // Zero flag register.
  always_ff @(posedge clk) begin
    if (rst) begin
      zero_q <= 1'b0;
    end else begin
      zero_q <= zero_d;
    end
  end

  assign zero_flag = zero_q;
`else
  assign zero_flag = 1'b0;
`endif

endmodule
